// File: rtl/wb_conbus_mux.sv
// Master-side mux and cycle controller for the shared Wishbone bus.
// Locks the arbiter's grant for one bus cycle and aborts transfers that are never acknowledged.
module wb_conbus_mux #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           m_cyc_i,
    input  logic [2:0]           m_stb_i,
    input  logic [2:0]           m_we_i,
    input  logic [3*AW-1:0]      m_adr_i,
    input  logic [3*DW-1:0]      m_dat_i,
    input  logic [3*DW/8-1:0]    m_sel_i,
    output logic [DW-1:0]        m_dat_o,
    output logic [2:0]           m_ack_o,
    output logic [2:0]           m_err_o,
    output logic [2:0]           req,
    input  logic [1:0]           gnt,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    output logic [DW/8-1:0]      s_sel_o,
    input  logic [DW-1:0]        s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    output logic                 timeout_o
);

    localparam int SW = DW / 8;
    localparam logic [7:0] WDT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_owner;
    logic [1:0]      w_owner_nxt;
    logic [7:0]      r_wdt;
    logic [7:0]      w_wdt_nxt;

    // Index 3 (no grant / invalid owner) reads as an idle master.
    logic [3:0]      w_cyc_ext;
    logic [3:0]      w_stb_ext;
    logic            w_own_cyc;
    logic            w_own_stb;
    logic            w_stall;
    logic [2:0]      w_own_hot;
    logic            w_own_we;
    logic [AW-1:0]   w_own_adr;
    logic [DW-1:0]   w_own_dat;
    logic [SW-1:0]   w_own_sel;

    assign w_cyc_ext = {1'b0, m_cyc_i};
    assign w_stb_ext = {1'b0, m_stb_i};
    assign w_own_cyc = w_cyc_ext[r_owner];
    assign w_own_stb = w_stb_ext[r_owner];
    assign w_stall   = w_own_stb & ~s_ack_i & ~s_err_i;

    assign req     = m_cyc_i;
    assign m_dat_o = s_dat_i;

    // Select the owner's request slice and one-hot response mask.
    always_comb begin
        w_own_hot = 3'b000;
        w_own_we  = 1'b0;
        w_own_adr = {AW{1'b0}};
        w_own_dat = {DW{1'b0}};
        w_own_sel = {SW{1'b0}};
        case (r_owner)
            2'd0: begin
                w_own_hot = 3'b001;
                w_own_we  = m_we_i[0];
                w_own_adr = m_adr_i[0*AW +: AW];
                w_own_dat = m_dat_i[0*DW +: DW];
                w_own_sel = m_sel_i[0*SW +: SW];
            end
            2'd1: begin
                w_own_hot = 3'b010;
                w_own_we  = m_we_i[1];
                w_own_adr = m_adr_i[1*AW +: AW];
                w_own_dat = m_dat_i[1*DW +: DW];
                w_own_sel = m_sel_i[1*SW +: SW];
            end
            2'd2: begin
                w_own_hot = 3'b100;
                w_own_we  = m_we_i[2];
                w_own_adr = m_adr_i[2*AW +: AW];
                w_own_dat = m_dat_i[2*DW +: DW];
                w_own_sel = m_sel_i[2*SW +: SW];
            end
            default: begin
                w_own_hot = 3'b000;
            end
        endcase
    end

    // Drive the shared bus and master responses from the current state.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = {AW{1'b0}};
        s_dat_o   = {DW{1'b0}};
        s_sel_o   = {SW{1'b0}};
        m_ack_o   = 3'b000;
        m_err_o   = 3'b000;
        timeout_o = 1'b0;
        case (r_state)
            ST_BUSY: begin
                s_cyc_o = w_own_cyc;
                s_stb_o = w_own_stb;
                s_we_o  = w_own_we;
                s_adr_o = w_own_adr;
                s_dat_o = w_own_dat;
                s_sel_o = w_own_sel;
                m_ack_o = w_own_hot & {3{s_ack_i}};
                m_err_o = w_own_hot & {3{s_err_i}};
            end
            ST_ABORT: begin
                m_err_o   = w_own_hot;
                timeout_o = 1'b1;
            end
            default: begin
                timeout_o = 1'b0;
            end
        endcase
    end

    // Next state, ownership lock and watchdog.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_wdt_nxt   = 8'd0;
        case (r_state)
            ST_IDLE: begin
                if ((gnt != 2'd3) && w_cyc_ext[gnt]) begin
                    w_state_nxt = ST_BUSY;
                    w_owner_nxt = gnt;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Cycle end outranks expiry; a response in the expiry cycle clears the stall.
                if (!w_own_cyc) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_stall) begin
                    if (r_wdt == WDT_LAST) begin
                        w_state_nxt = ST_ABORT;
                    end else begin
                        w_wdt_nxt = (r_wdt == 8'hFF) ? 8'hFF : (r_wdt + 8'd1);
                    end
                end else begin
                    w_wdt_nxt = 8'd0;
                end
            end
            ST_ABORT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_owner <= 2'd0;
            r_wdt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_wdt   <= w_wdt_nxt;
        end
    end

endmodule

// File: tb/tb_wb_conbus_mux.sv
// Scoreboard bench for wb_conbus_mux: a cycle-level reference model queues expected outputs,
// a monitor on the falling edge pops and compares them.
module tb_wb_conbus_mux;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        m_cyc_i, m_stb_i, m_we_i;
    logic [3*AW-1:0]   m_adr_i;
    logic [3*DW-1:0]   m_dat_i;
    logic [3*SW-1:0]   m_sel_i;
    logic [DW-1:0]     m_dat_o;
    logic [2:0]        m_ack_o, m_err_o, req;
    logic [1:0]        gnt;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack_i, s_err_i;
    logic              timeout_o;

    wb_conbus_mux #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .req(req), .gnt(gnt),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          scyc, sstb, swe;
        logic [AW-1:0] sadr;
        logic [DW-1:0] sdat;
        logic [SW-1:0] ssel;
        logic [2:0]    ack, err;
        logic          to;
        logic [2:0]    rq;
        logic [DW-1:0] mdat;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // pending stimulus, applied one clock at a time by step()
    logic            p_rst = 1'b0;
    logic [2:0]      p_cyc = 3'b000, p_stb = 3'b000, p_we = 3'b000;
    logic [1:0]      p_gnt = 2'd3;
    logic            p_ack = 1'b0, p_err = 1'b0;
    logic [3*AW-1:0] p_adr = '0;
    logic [3*DW-1:0] p_wdat = '0;
    logic [3*SW-1:0] p_sel = '0;
    logic [DW-1:0]   p_sdat = '0;
    logic            p_fix = 1'b0;

    // reference model: bus owner (-1 = none), pending abort, consecutive stalled strobes
    int mb_own   = -1;
    bit mb_abort = 1'b0;
    int mb_aown  = 0;
    int mb_stall = 0;
    int n_abort  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req_v);
        end
    endtask

    task automatic step();
        exp_t e;
        int   o;
        @(posedge clk);
        #1;
        if (!p_fix) begin
            p_adr  = {$urandom, $urandom, $urandom};
            p_wdat = {$urandom, $urandom, $urandom};
            p_sel  = 12'($urandom);
            p_sdat = $urandom;
        end
        rst = p_rst; m_cyc_i = p_cyc; m_stb_i = p_stb; m_we_i = p_we; gnt = p_gnt;
        s_ack_i = p_ack; s_err_i = p_err;
        m_adr_i = p_adr; m_dat_i = p_wdat; m_sel_i = p_sel; s_dat_i = p_sdat;
        e = '0;
        e.rq = p_cyc;
        e.mdat = p_sdat;
        if (mb_own >= 0) begin
            o = mb_own;
            e.scyc = p_cyc[o]; e.sstb = p_stb[o]; e.swe = p_we[o];
            e.sadr = p_adr[o*AW +: AW];
            e.sdat = p_wdat[o*DW +: DW];
            e.ssel = p_sel[o*SW +: SW];
            e.ack[o] = p_ack;
            e.err[o] = p_err;
        end else if (mb_abort) begin
            e.err[mb_aown] = 1'b1;
            e.to = 1'b1;
        end
        q.push_back(e);
        if (!p_rst) begin
            mb_own = -1; mb_abort = 1'b0; mb_stall = 0;
        end else if (mb_abort) begin
            mb_abort = 1'b0;
        end else if (mb_own < 0) begin
            mb_stall = 0;
            if (p_gnt != 2'd3 && p_cyc[p_gnt]) mb_own = int'(p_gnt);
        end else if (!p_cyc[mb_own]) begin
            mb_own = -1; mb_stall = 0;
        end else if (p_stb[mb_own] && !p_ack && !p_err) begin
            mb_stall++;
            if (mb_stall == TO) begin
                mb_abort = 1'b1; mb_aown = mb_own; mb_own = -1; mb_stall = 0; n_abort++;
            end
        end else begin
            mb_stall = 0;
        end
    endtask

    task automatic go(input logic r, input logic [2:0] c, input logic [2:0] s, input logic [2:0] w,
                      input logic [1:0] g, input logic a, input logic er, input int n);
        p_rst = r; p_cyc = c; p_stb = s; p_we = w; p_gnt = g; p_ack = a; p_err = er;
        for (int i = 0; i < n; i++) step();
    endtask

    // monitor: compare every presented cycle against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("s_cyc_o", 32'(s_cyc_o), 32'(e.scyc));
                chk("s_stb_o", 32'(s_stb_o), 32'(e.sstb));
                chk("s_we_o", 32'(s_we_o), 32'(e.swe));
                chk("s_adr_o", s_adr_o, e.sadr);
                chk("s_dat_o", s_dat_o, e.sdat);
                chk("s_sel_o", 32'(s_sel_o), 32'(e.ssel));
                chk("m_ack_o", 32'(m_ack_o), 32'(e.ack));
                chk("m_err_o", 32'(m_err_o), 32'(e.err));
                chk("timeout_o", 32'(timeout_o), 32'(e.to));
                chk("req", 32'(req), 32'(e.rq));
                chk("m_dat_o", m_dat_o, e.mdat);
            end
        end
    end

    initial begin
        rst = 1'b0; m_cyc_i = 3'b000; m_stb_i = 3'b000; m_we_i = 3'b000; gnt = 2'd3;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
        repeat (2) @(posedge clk);
        // reset state
        go(1'b0, 3'b000, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0, 2);

        // master 1 write to 0x100, slave acks on the second bus cycle
        p_fix = 1'b1;
        p_adr = {$urandom, 32'h0000_0100, $urandom};
        p_wdat = {$urandom, 32'hDEAD_BEEF, $urandom};
        p_sel = 12'hFFF; p_sdat = 32'h1234_5678;
        go(1'b1, 3'b010, 3'b010, 3'b010, 2'd1, 1'b0, 1'b0, 2);
        go(1'b1, 3'b010, 3'b010, 3'b010, 2'd1, 1'b1, 1'b0, 1);
        go(1'b1, 3'b000, 3'b000, 3'b000, 2'd1, 1'b0, 1'b0, 2);
        p_fix = 1'b0;

        // grant moves to master 2 while master 0 owns the bus
        go(1'b1, 3'b001, 3'b001, 3'b000, 2'd0, 1'b0, 1'b0, 1);
        go(1'b1, 3'b001, 3'b001, 3'b000, 2'd0, 1'b1, 1'b0, 1);
        go(1'b1, 3'b101, 3'b101, 3'b100, 2'd2, 1'b0, 1'b0, 2);
        go(1'b1, 3'b100, 3'b100, 3'b100, 2'd2, 1'b0, 1'b0, 2);
        go(1'b1, 3'b100, 3'b100, 3'b100, 2'd2, 1'b1, 1'b0, 1);
        go(1'b1, 3'b000, 3'b000, 3'b000, 2'd2, 1'b0, 1'b0, 2);

        // slave never answers: watchdog abort
        go(1'b1, 3'b100, 3'b100, 3'b000, 2'd2, 1'b0, 1'b0, 1);
        go(1'b1, 3'b100, 3'b100, 3'b000, 2'd3, 1'b0, 1'b0, 7);
        go(1'b1, 3'b000, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0, 2);

        // ack in the expiry cycle, then simultaneous ack and err
        go(1'b1, 3'b010, 3'b010, 3'b000, 2'd1, 1'b0, 1'b0, 4);
        go(1'b1, 3'b010, 3'b010, 3'b000, 2'd1, 1'b1, 1'b0, 1);
        go(1'b1, 3'b010, 3'b010, 3'b000, 2'd1, 1'b1, 1'b1, 1);
        go(1'b1, 3'b000, 3'b000, 3'b000, 2'd1, 1'b0, 1'b0, 2);

        // owner drops cyc in the expiry cycle
        go(1'b1, 3'b001, 3'b001, 3'b000, 2'd0, 1'b0, 1'b0, 4);
        go(1'b1, 3'b000, 3'b001, 3'b000, 2'd3, 1'b0, 1'b0, 3);

        // reset mid-transfer, then gnt = 3 with cyc high keeps the bus idle
        go(1'b1, 3'b001, 3'b001, 3'b001, 2'd0, 1'b0, 1'b0, 2);
        go(1'b0, 3'b001, 3'b001, 3'b001, 2'd0, 1'b0, 1'b0, 1);
        go(1'b1, 3'b001, 3'b001, 3'b001, 2'd3, 1'b0, 1'b0, 3);
        go(1'b1, 3'b000, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0, 1);

        // randomized traffic with sticky cyc lines and rare responses
        for (int i = 0; i < 3000; i++) begin
            p_rst = ($urandom_range(0, 199) != 0);
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 7) == 0) p_cyc[b] = ~p_cyc[b];
                p_stb[b] = ($urandom_range(0, 3) != 0);
                p_we[b]  = 1'($urandom);
            end
            p_gnt = 2'($urandom);
            p_ack = ($urandom_range(0, 4) == 0);
            p_err = ($urandom_range(0, 15) == 0);
            step();
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("info: modelled watchdog aborts = %0d", n_abort);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_conbus_mux.md
# wb_conbus_mux

Master-side data path and cycle controller for the shared Wishbone bus. Sits directly downstream of the 3-master priority arbiter: it presents master `cyc` lines to the arbiter as requests, takes the arbiter's grant, and locks ownership for the length of a bus cycle. While locked it routes the owner's signals onto the shared slave bus and returns `ack`/`err` only to that owner. A watchdog aborts slave transfers that are never acknowledged.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 255, watchdog limit in stalled-strobe cycles (1..255, 8-bit counter)

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset
- `m_cyc_i`  in  3  per-master `cyc`, bit n = master n
- `m_stb_i`  in  3  per-master `stb`
- `m_we_i`  in  3  per-master `we`
- `m_adr_i`  in  3*AW  master n in bits [n*AW +: AW]
- `m_dat_i`  in  3*DW  master n write data in bits [n*DW +: DW]
- `m_sel_i`  in  3*DW/8  master n byte selects
- `m_dat_o`  out  DW  read data broadcast to all masters, equal to `s_dat_i`
- `m_ack_o`  out  3  ack to owner only
- `m_err_o`  out  3  err to owner only, slave err or watchdog abort
- `req`  out  3  to arbiter, equal to `m_cyc_i`
- `gnt`  in  2  from arbiter: 0, 1 or 2 = master index; 3 = no grant
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  shared bus controls
- `s_adr_o`  out  AW  shared address
- `s_dat_o`  out  DW  shared write data
- `s_sel_o`  out  DW/8  shared byte selects
- `s_dat_i`  in  DW  slave read data
- `s_ack_i`, `s_err_i`  in  1 each  slave response
- `timeout_o`  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, BUSY, ABORT. Registers: `state`, `owner[1:0]`, `wdt[7:0]`.
- IDLE: if `gnt` < 3 and `m_cyc_i[gnt]` = 1, then `owner` <= `gnt` and go to BUSY. Otherwise stay in IDLE. `gnt` = 3 never starts a cycle.
- BUSY:
  - `s_cyc_o` = `m_cyc_i[owner]`, `s_stb_o` = `m_stb_i[owner]`.
  - `s_we_o`, `s_adr_o`, `s_dat_o`, `s_sel_o` come from the owner's slice.
  - `m_ack_o[owner]` = `s_ack_i`, `m_err_o[owner]` = `s_err_i`; all other bits are 0.
  - These paths are combinational.
- Grant changes during BUSY are ignored; `owner` holds until the cycle ends.
- BUSY -> IDLE when `m_cyc_i[owner]` is sampled 0. The next owner is sampled from `gnt` in IDLE, so there is at least one IDLE cycle between owners.
- Watchdog:
  - In BUSY, `wdt` increments each cycle with `s_stb_o` = 1 and `s_ack_i` = `s_err_i` = 0.
  - `wdt` clears on `s_ack_i`, on `s_err_i`, on `s_stb_o` = 0, and on leaving BUSY.
  - When `wdt` = TIMEOUT-1 and the current cycle is still stalled, go to ABORT.
- ABORT lasts exactly one cycle:
  - `s_cyc_o` = `s_stb_o` = 0.
  - `m_err_o[owner]` = 1, `timeout_o` = 1.
  - Next state is IDLE.
- Outside BUSY: all `s_*_o` outputs are 0, `m_ack_o` = 0, and `m_err_o` = 0 (except during ABORT as above).
- Width rule: `wdt` saturates at 255 and never wraps.

## Timing
- Reset (`rst` = 0 at a clock edge): `state` = IDLE, `owner` = 0, `wdt` = 0. All outputs 0 except `req`/`m_dat_o`, which follow their inputs.
- Reset mid-transfer drops `s_cyc_o` in the cycle after the edge. No ack or err is issued.
- Latency:
  - `m_cyc_i` rising to `s_cyc_o` rising: 1 cycle, given `gnt` already points at the master. The arbiter grant latency adds on top.
  - Ack/err and read data to the master: 0 cycles (combinational).
- Simultaneous `s_ack_i` and watchdog expiry: the ack wins. It is routed, `wdt` clears, and there is no abort.
- Simultaneous `s_ack_i` and `s_err_i`: both are forwarded unchanged.
- Owner drops `cyc` in the same cycle as expiry: go to IDLE, no abort.
- Back-to-back transfers under one `cyc`: stay in BUSY; `wdt` restarts per strobe.

## Test plan
- Master 1 raises `cyc`/`stb`, `we` = 1, `adr` = 0x100, data = 0xDEADBEEF, `gnt` = 1; slave acks on the 2nd bus cycle. Required: `s_adr_o` = 0x100 and `s_dat_o` = 0xDEADBEEF from cycle +1, `m_ack_o` = 3'b010 for one cycle, return to IDLE after `cyc` drops.
- While master 0 owns BUSY, switch `gnt` to 2 with `m_cyc_i` = 3'b101. Required: the bus stays on master 0 until its `cyc` drops, then one IDLE cycle, then master 2 owns.
- Slave never acks with TIMEOUT = 4. Required: `s_stb_o` high for 4 cycles, then `s_cyc_o` = 0, `m_err_o[owner]` = 1 and `timeout_o` = 1 for exactly one cycle, then IDLE.
- Ack arrives in the cycle the watchdog would expire. Required: `m_ack_o` pulses, no `m_err_o`, no `timeout_o`.
- Assert `rst` = 0 mid-BUSY. Required: next cycle all `s_*_o`, `m_ack_o` and `m_err_o` are 0 and `state` = IDLE; `gnt` = 3 with `cyc` high keeps it in IDLE.
